// File: rtl/reset_cmd_issuer.sv
// Issues a reset command byte, then measures the width of the returned
// active-low reset pulse, aborting any wait phase after TIMEOUT_CYC cycles.
module reset_cmd_issuer #(
    parameter logic [7:0]  CMD_CODE    = 8'd55,
    parameter int unsigned CMD_HOLD    = 2,
    parameter logic [31:0] TIMEOUT_CYC = 32'd500000000,
    parameter logic [31:0] MIN_PULSE   = 32'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        reset_in_n,
    output logic [7:0]  reset_db,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        short_err,
    output logic [31:0] pulse_width
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        MEASURE,
        FIN
    } state_t;

    // CMD_HOLD below 1 behaves as 1: ISSUE always lasts at least one cycle.
    localparam logic [31:0] HOLD_LAST = (CMD_HOLD == 0) ? 32'd0 : 32'(CMD_HOLD - 1);
    localparam logic [31:0] WIDTH_MAX = 32'hFFFF_FFFF;

    state_t      state, state_nxt;
    logic        sync_1, sync_n;
    logic [31:0] phase_cnt, phase_nxt;
    logic [31:0] width_cnt, width_nxt;
    logic [31:0] pulse_width_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sync_1      <= 1'b1;
            sync_n      <= 1'b1;
            phase_cnt   <= 32'd0;
            width_cnt   <= 32'd0;
            pulse_width <= 32'd0;
        end else begin
            state       <= state_nxt;
            sync_1      <= reset_in_n;
            sync_n      <= sync_1;
            phase_cnt   <= phase_nxt;
            width_cnt   <= width_nxt;
            pulse_width <= pulse_width_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        phase_nxt       = phase_cnt;
        width_nxt       = width_cnt;
        pulse_width_nxt = pulse_width;
        reset_db        = 8'd0;
        busy            = (state != IDLE);
        done            = 1'b0;
        timeout         = 1'b0;
        short_err       = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = ISSUE;
                    phase_nxt = 32'd0;
                end
            end
            ISSUE: begin
                reset_db = CMD_CODE;
                if (phase_cnt >= HOLD_LAST) begin
                    state_nxt = WAIT_LOW;
                    phase_nxt = 32'd0;
                end else begin
                    phase_nxt = phase_cnt + 32'd1;
                end
            end
            WAIT_LOW: begin
                phase_nxt = phase_cnt + 32'd1;
                // A low already present on entry counts as the pulse start.
                if (!sync_n) begin
                    state_nxt = MEASURE;
                    width_nxt = 32'd1;
                end else if (phase_cnt == TIMEOUT_CYC - 32'd1) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            MEASURE: begin
                if (sync_n) begin
                    state_nxt       = FIN;
                    pulse_width_nxt = width_cnt;
                end else if (width_cnt == TIMEOUT_CYC) begin
                    timeout         = 1'b1;
                    pulse_width_nxt = TIMEOUT_CYC;
                    state_nxt       = IDLE;
                end else if (width_cnt != WIDTH_MAX) begin
                    width_nxt = width_cnt + 32'd1;
                end
            end
            FIN: begin
                done      = 1'b1;
                short_err = (pulse_width < MIN_PULSE);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reset_cmd_issuer.sv
// Randomized bench for reset_cmd_issuer: per-cycle comparison against a
// timeline model built up front from the stimulus, plus pinned literal points.
module tb_reset_cmd_issuer;

    localparam int          N       = 6000;
    localparam int          HOLD    = 2;
    localparam int          TMO     = 100;
    localparam int          MINP    = 4;
    localparam logic [7:0]  CMD     = 8'd55;
    localparam int          RND_BEG = 600;

    logic        clk;
    logic        reset;
    logic        req;
    logic        reset_in_n;
    logic [7:0]  reset_db;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        short_err;
    logic [31:0] pulse_width;

    reset_cmd_issuer #(
        .CMD_CODE    (CMD),
        .CMD_HOLD    (HOLD),
        .TIMEOUT_CYC (32'd100),
        .MIN_PULSE   (32'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .reset_in_n  (reset_in_n),
        .reset_db    (reset_db),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .short_err   (short_err),
        .pulse_width (pulse_width)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Stimulus per cycle and the synchronized view of reset_in_n.
    bit rst_a[N];
    bit req_a[N];
    bit rin_a[N];
    bit sn_a[N];

    // Expected outputs per cycle.
    logic [7:0]  e_db[N];
    bit          e_busy[N];
    bit          e_done[N];
    bit          e_to[N];
    bit          e_short[N];
    int unsigned e_pw[N];

    int          pin_cyc[$];
    int          pin_sig[$];
    int unsigned pin_val[$];

    int checks = 0;
    int errors = 0;

    string sig_name[6] = '{"reset_db", "busy", "done", "timeout", "short_err", "pulse_width"};
    int unsigned low_lens[11] = '{1, 2, 3, 4, 5, 10, 37, 99, 100, 101, 180};

    task automatic check(input string name, input int cyc, input longint unsigned act,
                         input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic put(input int k, input logic [7:0] db, input bit b, input bit d, input bit t,
                       input bit s, input int unsigned p);
        if (k < N) begin
            e_db[k]    = db;
            e_busy[k]  = b;
            e_done[k]  = d;
            e_to[k]    = t;
            e_short[k] = s;
            e_pw[k]    = p;
        end
    endtask

    task automatic pin(input int cyc, input int sig, input int unsigned val);
        pin_cyc.push_back(cyc);
        pin_sig.push_back(sig);
        pin_val.push_back(val);
    endtask

    function automatic int unsigned model_val(input int sig, input int c);
        case (sig)
            0:       return int'(e_db[c]);
            1:       return int'(e_busy[c]);
            2:       return int'(e_done[c]);
            3:       return int'(e_to[c]);
            4:       return int'(e_short[c]);
            default: return e_pw[c];
        endcase
    endfunction

    function automatic int unsigned dut_val(input int sig);
        case (sig)
            0:       return int'(reset_db);
            1:       return int'(busy);
            2:       return int'(done);
            3:       return int'(timeout);
            4:       return int'(short_err);
            default: return pulse_width;
        endcase
    endfunction

    task automatic gen_stimulus();
        int pos;
        for (int c = 0; c < N; c++) begin
            rst_a[c] = 1'b0;
            req_a[c] = 1'b0;
            rin_a[c] = 1'b1;
        end
        for (int c = 0; c <= 2; c++) rst_a[c] = 1'b1;
        // Normal 10-cycle pulse, plus a req on the FIN cycle that must be dropped.
        req_a[5] = 1'b1;
        for (int c = 11; c <= 20; c++) rin_a[c] = 1'b0;
        req_a[24] = 1'b1;
        // No pulse at all: wait-phase timeout.
        req_a[40] = 1'b1;
        // Short pulse, with a second req while busy.
        req_a[150] = 1'b1;
        req_a[155] = 1'b1;
        rin_a[160] = 1'b0;
        rin_a[161] = 1'b0;
        // Pulse that never ends within the limit.
        req_a[200] = 1'b1;
        for (int c = 210; c <= 509; c++) rin_a[c] = 1'b0;
        // Reset during MEASURE, then a fresh request.
        req_a[520] = 1'b1;
        for (int c = 530; c <= 569; c++) rin_a[c] = 1'b0;
        rst_a[540] = 1'b1;
        req_a[545] = 1'b1;

        pos = RND_BEG;
        while (pos < N) begin
            pos += $urandom_range(1, 250);
            for (int i = 0; i < int'(low_lens[$urandom_range(0, 10)]) && pos < N; i++) begin
                rin_a[pos] = 1'b0;
                pos++;
            end
        end
        for (int c = RND_BEG; c < N; c++) begin
            req_a[c] = ($urandom_range(0, 19) == 0);
            rst_a[c] = ($urandom_range(0, 999) == 0);
        end

        for (int c = 0; c < N; c++) begin
            if (c < 2) sn_a[c] = 1'b1;
            else if (rst_a[c-1] || rst_a[c-2]) sn_a[c] = 1'b1;
            else sn_a[c] = rin_a[c-2];
        end
    endtask

    // Walks the timeline one request at a time: issue window, wait window,
    // then the low run length decides done/short/timeout and the width.
    task automatic build_model();
        int c, k, k0, j, len, last;
        int unsigned pw;
        bit ab, lowseen, tmo, fin;
        pw = 0;
        c  = 0;
        while (c < N) begin
            put(c, 8'd0, 0, 0, 0, 0, pw);
            if (rst_a[c]) begin
                pw = 0;
                c++;
            end else if (!req_a[c]) begin
                c++;
            end else begin
                k  = c + 1;
                ab = 1'b0;
                k0 = -1;
                for (j = 0; j < HOLD && !ab && k < N; j++) begin
                    put(k, CMD, 1, 0, 0, 0, pw);
                    if (rst_a[k]) ab = 1'b1;
                    k++;
                end
                j = 0;
                while (!ab && k0 < 0 && k < N) begin
                    lowseen = !sn_a[k];
                    tmo     = !lowseen && (j == TMO - 1);
                    put(k, 8'd0, 1, 0, tmo, 0, pw);
                    if (rst_a[k]) ab = 1'b1;
                    else if (lowseen) k0 = k;
                    k++;
                    if (tmo) break;
                    j++;
                end
                if (!ab && k0 >= 0) begin
                    len = 0;
                    while (k0 + len < N && !sn_a[k0 + len]) len++;
                    last = (len <= TMO) ? k0 + len + 1 : k0 + TMO;
                    for (k = k0 + 1; k <= last && k < N && !ab; k++) begin
                        fin = (len <= TMO) && (k == last);
                        tmo = (len > TMO) && (k == last);
                        put(k, 8'd0, 1, fin, tmo, fin && (len < MINP),
                            fin ? int'(len) : pw);
                        if (rst_a[k]) ab = 1'b1;
                    end
                    if (!ab) pw = (len <= TMO) ? len : TMO;
                end
                if (ab) pw = 0;
                c = k;
            end
        end
    endtask

    initial begin
        gen_stimulus();
        build_model();

        // Hand-derived points: sig 0 db, 1 busy, 2 done, 3 timeout, 4 short, 5 width.
        pin(3, 5, 0);     pin(3, 1, 0);
        pin(6, 0, 55);    pin(7, 0, 55);    pin(8, 0, 0);     pin(8, 1, 1);
        pin(24, 2, 1);    pin(24, 5, 10);   pin(24, 4, 0);
        pin(25, 1, 0);    pin(26, 1, 0);
        pin(141, 3, 0);   pin(142, 3, 1);   pin(143, 1, 0);
        pin(156, 0, 0);
        pin(165, 2, 1);   pin(165, 4, 1);   pin(165, 5, 2);
        pin(312, 3, 1);   pin(313, 5, 100); pin(313, 1, 0);
        pin(540, 5, 100); pin(541, 1, 0);   pin(541, 5, 0);
        pin(573, 2, 1);   pin(573, 5, 24);

        for (int i = 0; i < pin_cyc.size(); i++) begin
            check({"model_", sig_name[pin_sig[i]]}, pin_cyc[i],
                  model_val(pin_sig[i], pin_cyc[i]), pin_val[i]);
        end

        reset      = 1'b1;
        req        = 1'b0;
        reset_in_n = 1'b1;
        for (int c = 0; c < N; c++) begin
            reset      = rst_a[c];
            req        = req_a[c];
            reset_in_n = rin_a[c];
            @(negedge clk);
            if (c >= 1) begin
                check("reset_db", c, reset_db, e_db[c]);
                check("busy", c, busy, e_busy[c]);
                check("done", c, done, e_done[c]);
                check("timeout", c, timeout, e_to[c]);
                check("short_err", c, short_err, e_short[c]);
                check("pulse_width", c, pulse_width, e_pw[c]);
                for (int i = 0; i < pin_cyc.size(); i++) begin
                    if (pin_cyc[i] == c) begin
                        check({"pin_", sig_name[pin_sig[i]]}, c, dut_val(pin_sig[i]),
                              pin_val[i]);
                    end
                end
            end
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_cmd_issuer.md
RESET_CMD_ISSUER -- requirements
Module: reset_cmd_issuer

Interface
REQ-001 Parameter CMD_CODE, default 8'd55: command byte that triggers the delayed-reset responder.
REQ-002 Parameter CMD_HOLD, default 2: number of cycles CMD_CODE is driven on reset_db.
REQ-003 Parameter TIMEOUT_CYC, default 32'd500000000: cycle limit per wait phase.
REQ-004 Parameter MIN_PULSE, default 32'd1: minimum acceptable low-pulse width, in cycles.
REQ-005 clk  in  1: single clock, rising edge.
REQ-006 reset  in  1: synchronous, active-high reset.
REQ-007 req  in  1: one-cycle request to issue a reset command.
REQ-008 reset_in_n  in  1: active-low reset pulse returned by the responder.
REQ-009 reset_db  out  8: command byte to the responder.
REQ-010 busy  out  1: high in every state except IDLE.
REQ-011 done  out  1: one-cycle pulse marking a completed, valid pulse measurement.
REQ-012 timeout  out  1: one-cycle pulse marking an aborted sequence.
REQ-013 short_err  out  1: one-cycle pulse, coincident with done, when width < MIN_PULSE.
REQ-014 pulse_width  out  32: measured low width of the last pulse, in cycles.

Function
REQ-015 The block SHALL pass reset_in_n through a 2-flop synchronizer (sync_n); both flops load 1 on reset, giving 2 cycles of latency.
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT_LOW, MEASURE and FIN.
REQ-017 IDLE: on req=1 the FSM SHALL go to ISSUE and clear the phase counter; otherwise it stays in IDLE.
REQ-018 ISSUE: reset_db SHALL equal CMD_CODE for exactly CMD_HOLD cycles, then the FSM SHALL go to WAIT_LOW and clear the phase counter.
REQ-019 In all states other than ISSUE, reset_db SHALL be 8'd0.
REQ-020 WAIT_LOW: the phase counter SHALL increment each cycle.
REQ-021 WAIT_LOW: if sync_n=0, the FSM SHALL go to MEASURE and load the width counter with 1.
REQ-022 WAIT_LOW: else if the phase counter reaches TIMEOUT_CYC-1, the FSM SHALL pulse timeout and go to IDLE.
REQ-023 MEASURE: while sync_n=0, the width counter SHALL increment, saturating at 32'hFFFFFFFF without wrapping.
REQ-024 MEASURE: on sync_n=1, the FSM SHALL go to FIN and pulse_width SHALL load the width counter.
REQ-025 MEASURE: if the width counter reaches TIMEOUT_CYC while still low, the FSM SHALL pulse timeout, load pulse_width with TIMEOUT_CYC and go to IDLE.
REQ-026 FIN: the block SHALL pulse done for one cycle, pulse short_err in the same cycle if pulse_width < MIN_PULSE, then go to IDLE.
REQ-027 req asserted in any state other than IDLE SHALL be ignored, with no queuing.
REQ-028 req asserted in the same cycle as the FSM returns to IDLE SHALL be ignored; it is accepted from the following cycle.
REQ-029 pulse_width SHALL hold its value until the next load.
REQ-030 done and timeout SHALL never be asserted in the same cycle.
REQ-031 A low on reset_in_n that is already present when the FSM enters WAIT_LOW SHALL be measured as a pulse; there is no edge qualification.
REQ-032 All counters SHALL be 32-bit and unsigned.

Reset
REQ-033 When reset=1 at a clk edge, the FSM SHALL go to IDLE and reset_db, busy, done, timeout, short_err, pulse_width and all counters SHALL be 0.
REQ-034 Reset asserted mid-sequence SHALL abort the sequence with no done or timeout pulse.
REQ-035 reset SHALL have priority over req.

Verification (CMD_HOLD=2, TIMEOUT_CYC=100, MIN_PULSE=4)
REQ-036 req pulse, reset_in_n held low for 10 cycles starting 5 cycles after issue -> reset_db=55 for 2 cycles, then done=1 and pulse_width=10, no short_err.
REQ-037 req pulse, reset_in_n never goes low -> timeout=1 exactly 100 cycles after WAIT_LOW entry, then busy=0.
REQ-038 req pulse, reset_in_n low for 2 cycles -> done=1, short_err=1, pulse_width=2.
REQ-039 req pulse, reset_in_n held low indefinitely -> timeout=1, pulse_width=100.
REQ-040 Second req pulse while busy=1 -> exactly one ISSUE phase and one done pulse.
REQ-041 reset asserted during MEASURE -> all outputs 0 on the next cycle, no done; a new req is then accepted normally.
